control_fsm: RTL and testbench
==============================

Name: control_fsm

Overview:
- Controller state machine that sits directly downstream of the instruction register and consumes its 16-bit output.
- Sequences fetch/decode/execute for the 16-bit processor.
- Drives IR load enable, program-counter clear/increment, data-memory address/write, register-file addresses/enables, and the ALU select.
- Moore-style: every control output is a pure function of the current state and the registered instruction word.

Parameters:
- D_ADDR_W, 8: data-memory address width (instruction bits [11:4] for LOAD/STORE).
- RF_ADDR_W, 4: register-file address width.
- ALU_SEL_W, 3: ALU select width.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- IR  input  16  instruction from the instruction register.
- PC_Clr  output  1  clear program counter.
- IR_Ld  output  1  load enable to the instruction register.
- PC_Up  output  1  increment program counter.
- D_Addr  output  D_ADDR_W  data-memory address.
- D_Wr  output  1  data-memory write enable.
- RF_s  output  1  register-file write mux: 1 = memory data, 0 = ALU result.
- RF_W_Addr  output  RF_ADDR_W  register-file write address.
- RF_W_en  output  1  register-file write enable.
- RF_Ra_Addr  output  RF_ADDR_W  read port A address.
- RF_Rb_Addr  output  RF_ADDR_W  read port B address.
- ALU_s0  output  ALU_SEL_W  ALU operation select.
- OutState  output  4  current state encoding.

Behaviour:
- One clock domain (Clk); Reset is asynchronous and active-high.
- Reset forces state INIT immediately, mid-instruction included. No partial write survives: D_Wr and RF_W_en drop the moment Reset asserts.
- Output values in INIT: PC_Clr=1, all other controls 0, all addresses 0, ALU_s0=0, OutState=INIT.
- Opcode = IR[15:12]:
  - NOOP=0000
  - STORE=0001: D_Addr=IR[11:4], Rn=IR[3:0]
  - LOAD=0010: D_Addr=IR[11:4], Rn=IR[3:0]
  - ADD=0011: Ra=IR[11:8], Rb=IR[7:4], Rd=IR[3:0]
  - SUB=0100: same fields as ADD
  - HALT=0101
  - 0110..1111: illegal
- States and transitions (one clock each unless stated):
  - INIT -> FETCH.
  - FETCH: IR_Ld=1, PC_Up=1 -> DECODE. The IR captures the new word at this edge, so IR is valid throughout DECODE.
  - DECODE: all enables 0. Next state by opcode: NOOP/illegal -> NOOP, LOAD -> LOAD_A, STORE -> STORE, ADD -> ADD, SUB -> SUB, HALT -> HALT.
  - NOOP -> FETCH.
  - LOAD_A: D_Addr=IR[11:4], RF_s=1, RF_W_Addr=IR[3:0], no write -> LOAD_B. This cycle covers synchronous memory read latency.
  - LOAD_B: same outputs as LOAD_A plus RF_W_en=1 -> FETCH.
  - STORE: D_Addr=IR[11:4], RF_Ra_Addr=IR[3:0], D_Wr=1 -> FETCH.
  - ADD: RF_Ra_Addr=IR[11:8], RF_Rb_Addr=IR[7:4], RF_W_Addr=IR[3:0], RF_W_en=1, RF_s=0, ALU_s0=3'b001 -> FETCH.
  - SUB: same as ADD with ALU_s0=3'b010 -> FETCH.
  - HALT: all enables 0; holds until Reset.
- Instruction latency:
  - NOOP/STORE/ADD/SUB: 3 cycles (FETCH, DECODE, EXEC).
  - LOAD: 4 cycles.
- Outputs are decoded only from state and IR, with no extra register stage. IR changes only in FETCH, so outputs are stable through each execute cycle.
- Reads of register 0 or writes to Rd=Rn are ordinary; no hazard logic is needed because only one instruction is in flight.
- An unknown state encoding recovers to INIT on the next edge.

Optional Feature:
- Macro: CTRL_ILLEGAL_OP_TRAP_EN.
- Defined: an illegal opcode in DECODE -> HALT, and the machine stops.
- Undefined: an illegal opcode is treated as NOOP and execution continues at the next PC.
- NOOP behaviour is otherwise identical in both builds.

Decomposition:
- Shared package ctrl_pkg:
  - opcode_t enum (4-bit)
  - state_t enum (4-bit: INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_B, STORE, ADD, SUB, HALT)
  - ALU select constants ALU_PASS=0, ALU_ADD=1, ALU_SUB=2
  - width constants
- One sub-module is natural: control_decode, the combinational state+IR to control-output decoder. control_fsm holds only the state register and next-state logic.

Test Plan:
- Reset asserted mid-ADD (RF_W_en=1): outputs clear asynchronously before the next edge, OutState=INIT, PC_Clr=1. After release, FETCH with IR_Ld=1 and PC_Up=1 one cycle later.
- IR=16'h2A53 (LOAD 0xA5 -> R3): sequence FETCH, DECODE, LOAD_A, LOAD_B.
  - LOAD_A: D_Addr=8'hA5, RF_s=1, RF_W_en=0.
  - LOAD_B: RF_W_en=1, RF_W_addr=3.
- IR=16'h17F2 (STORE R2 -> 0x7F): D_Wr=1 for exactly one cycle with D_Addr=8'h7F and RF_Ra_Addr=2, then FETCH.
- IR=16'h3123 then 16'h4456:
  - ADD cycle: Ra=1, Rb=2, Rd=3, ALU_s0=1, RF_s=0.
  - SUB cycle: Ra=4, Rb=5, Rd=6, ALU_s0=2.
  - Each instruction takes 3 cycles.
- IR=16'h5000 (HALT): FSM stays in HALT for 50 cycles with all enables 0, regardless of IR changes; recovers only on Reset.
- IR=16'hF000 (illegal):
  - Without the macro: NOOP, then FETCH.
  - With CTRL_ILLEGAL_OP_TRAP_EN: HALT and stays there.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the 16-bit processor controller.
// Opcode and state enums, ALU select codes and field widths.
package ctrl_pkg;

    localparam int CTRL_IR_W      = 16;
    localparam int CTRL_D_ADDR_W  = 8;
    localparam int CTRL_RF_ADDR_W = 4;
    localparam int CTRL_ALU_SEL_W = 3;
    localparam int CTRL_STATE_W   = 4;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5
    } opcode_t;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_NOOP   = 4'd3,
        S_LOAD_A = 4'd4,
        S_LOAD_B = 4'd5,
        S_STORE  = 4'd6,
        S_ADD    = 4'd7,
        S_SUB    = 4'd8,
        S_HALT   = 4'd9
    } state_t;

    localparam logic [CTRL_ALU_SEL_W-1:0] ALU_PASS = 3'd0;
    localparam logic [CTRL_ALU_SEL_W-1:0] ALU_ADD  = 3'd1;
    localparam logic [CTRL_ALU_SEL_W-1:0] ALU_SUB  = 3'd2;

    function automatic logic [3:0] ir_opcode(
        input logic [CTRL_IR_W-1:0] ir
    );
        return ir[15:12];
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Controller <-> datapath bundle: instruction word in, control strobes out.
// master is the controller side, slave the datapath side.
interface control_fsm_if #(
    parameter int D_ADDR_W  = 8,
    parameter int RF_ADDR_W = 4,
    parameter int ALU_SEL_W = 3
);

    logic [15:0]          IR;
    logic                 PC_Clr;
    logic                 IR_Ld;
    logic                 PC_Up;
    logic [D_ADDR_W-1:0]  D_Addr;
    logic                 D_Wr;
    logic                 RF_s;
    logic [RF_ADDR_W-1:0] RF_W_Addr;
    logic                 RF_W_en;
    logic [RF_ADDR_W-1:0] RF_Ra_Addr;
    logic [RF_ADDR_W-1:0] RF_Rb_Addr;
    logic [ALU_SEL_W-1:0] ALU_s0;
    logic [3:0]           OutState;

    modport master (
        input  IR,
        output PC_Clr,
        output IR_Ld,
        output PC_Up,
        output D_Addr,
        output D_Wr,
        output RF_s,
        output RF_W_Addr,
        output RF_W_en,
        output RF_Ra_Addr,
        output RF_Rb_Addr,
        output ALU_s0,
        output OutState
    );

    modport slave (
        output IR,
        input  PC_Clr,
        input  IR_Ld,
        input  PC_Up,
        input  D_Addr,
        input  D_Wr,
        input  RF_s,
        input  RF_W_Addr,
        input  RF_W_en,
        input  RF_Ra_Addr,
        input  RF_Rb_Addr,
        input  ALU_s0,
        input  OutState
    );

endinterface

// File: rtl/control_decode.sv
// Combinational Moore decoder: current state + instruction fields -> controls.
// Only IR[11:0] is needed here; the opcode is consumed by the next-state logic.
module control_decode
    import ctrl_pkg::*;
#(
    parameter int D_ADDR_W  = CTRL_D_ADDR_W,
    parameter int RF_ADDR_W = CTRL_RF_ADDR_W,
    parameter int ALU_SEL_W = CTRL_ALU_SEL_W
) (
    input  state_t               state,
    input  logic [11:0]          fld,
    output logic                 pc_clr,
    output logic                 ir_ld,
    output logic                 pc_up,
    output logic [D_ADDR_W-1:0]  d_addr,
    output logic                 d_wr,
    output logic                 rf_s,
    output logic [RF_ADDR_W-1:0] rf_w_addr,
    output logic                 rf_w_en,
    output logic [RF_ADDR_W-1:0] rf_ra_addr,
    output logic [RF_ADDR_W-1:0] rf_rb_addr,
    output logic [ALU_SEL_W-1:0] alu_sel
);

    logic [D_ADDR_W-1:0]  mem_addr;
    logic [RF_ADDR_W-1:0] f_ra;
    logic [RF_ADDR_W-1:0] f_rb;
    logic [RF_ADDR_W-1:0] f_rd;

    assign mem_addr = D_ADDR_W'(fld[11:4]);
    assign f_ra     = RF_ADDR_W'(fld[11:8]);
    assign f_rb     = RF_ADDR_W'(fld[7:4]);
    assign f_rd     = RF_ADDR_W'(fld[3:0]);

    always_comb begin
        pc_clr     = 1'b0;
        ir_ld      = 1'b0;
        pc_up      = 1'b0;
        d_addr     = '0;
        d_wr       = 1'b0;
        rf_s       = 1'b0;
        rf_w_addr  = '0;
        rf_w_en    = 1'b0;
        rf_ra_addr = '0;
        rf_rb_addr = '0;
        alu_sel    = ALU_SEL_W'(ALU_PASS);

        unique case (state)
            S_INIT: begin
                pc_clr = 1'b1;
            end
            S_FETCH: begin
                ir_ld = 1'b1;
                pc_up = 1'b1;
            end
            S_LOAD_A: begin
                d_addr    = mem_addr;
                rf_s      = 1'b1;
                rf_w_addr = f_rd;
            end
            S_LOAD_B: begin
                // Memory data is valid now, one cycle after the address.
                d_addr    = mem_addr;
                rf_s      = 1'b1;
                rf_w_addr = f_rd;
                rf_w_en   = 1'b1;
            end
            S_STORE: begin
                d_addr     = mem_addr;
                rf_ra_addr = f_rd;
                d_wr       = 1'b1;
            end
            S_ADD: begin
                rf_ra_addr = f_ra;
                rf_rb_addr = f_rb;
                rf_w_addr  = f_rd;
                rf_w_en    = 1'b1;
                alu_sel    = ALU_SEL_W'(ALU_ADD);
            end
            S_SUB: begin
                rf_ra_addr = f_ra;
                rf_rb_addr = f_rb;
                rf_w_addr  = f_rd;
                rf_w_en    = 1'b1;
                alu_sel    = ALU_SEL_W'(ALU_SUB);
            end
            S_DECODE,
            S_NOOP,
            S_HALT: begin
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Fetch/decode/execute sequencer for the 16-bit processor.
// Define CTRL_ILLEGAL_OP_TRAP_EN to halt on illegal opcodes instead of skipping them.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int D_ADDR_W  = CTRL_D_ADDR_W,
    parameter int RF_ADDR_W = CTRL_RF_ADDR_W,
    parameter int ALU_SEL_W = CTRL_ALU_SEL_W
) (
    input  logic          Clk,
    input  logic          Reset,
    control_fsm_if.master bus
);

    state_t     state;
    state_t     state_nx;
    logic [3:0] opcode;

    assign opcode = ir_opcode(bus.IR);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = S_INIT;
        unique case (state)
            S_INIT:   state_nx = S_FETCH;
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_NOOP:  state_nx = S_NOOP;
                    OP_STORE: state_nx = S_STORE;
                    OP_LOAD:  state_nx = S_LOAD_A;
                    OP_ADD:   state_nx = S_ADD;
                    OP_SUB:   state_nx = S_SUB;
                    OP_HALT:  state_nx = S_HALT;
`ifdef CTRL_ILLEGAL_OP_TRAP_EN
                    default:  state_nx = S_HALT;
`else
                    default:  state_nx = S_NOOP;
`endif
                endcase
            end
            S_NOOP:   state_nx = S_FETCH;
            S_LOAD_A: state_nx = S_LOAD_B;
            S_LOAD_B: state_nx = S_FETCH;
            S_STORE:  state_nx = S_FETCH;
            S_ADD:    state_nx = S_FETCH;
            S_SUB:    state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            // Corrupted encodings fall back to a clean restart.
            default:  state_nx = S_INIT;
        endcase
    end

    control_decode #(
        .D_ADDR_W  (D_ADDR_W),
        .RF_ADDR_W (RF_ADDR_W),
        .ALU_SEL_W (ALU_SEL_W)
    ) u_decode (
        .state      (state),
        .fld        (bus.IR[11:0]),
        .pc_clr     (bus.PC_Clr),
        .ir_ld      (bus.IR_Ld),
        .pc_up      (bus.PC_Up),
        .d_addr     (bus.D_Addr),
        .d_wr       (bus.D_Wr),
        .rf_s       (bus.RF_s),
        .rf_w_addr  (bus.RF_W_Addr),
        .rf_w_en    (bus.RF_W_en),
        .rf_ra_addr (bus.RF_Ra_Addr),
        .rf_rb_addr (bus.RF_Rb_Addr),
        .alu_sel    (bus.ALU_s0)
    );

    assign bus.OutState = state;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed and random instructions against a
// per-instruction cycle-table model of the controller.
module tb_control_fsm;

    localparam int ST_INIT   = 0;
    localparam int ST_FETCH  = 1;
    localparam int ST_DECODE = 2;
    localparam int ST_NOOP   = 3;
    localparam int ST_LOAD_A = 4;
    localparam int ST_LOAD_B = 5;
    localparam int ST_STORE  = 6;
    localparam int ST_ADD    = 7;
    localparam int ST_SUB    = 8;
    localparam int ST_HALT   = 9;

    typedef struct packed {
        logic       pc_clr;
        logic       ir_ld;
        logic       pc_up;
        logic       d_wr;
        logic       rf_s;
        logic       w_en;
        logic [7:0] d_addr;
        logic [3:0] w_addr;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [2:0] alu;
        logic [3:0] st;
    } exp_t;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    control_fsm_if bus ();

    control_fsm dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input int st);
        exp_t e;
        e = '0;
        e.st = 4'(st);
        if (st == ST_INIT) e.pc_clr = 1'b1;
        if (st == ST_FETCH) begin
            e.ir_ld = 1'b1;
            e.pc_up = 1'b1;
        end
        return e;
    endfunction

    function automatic exp_t observe();
        exp_t g;
        g.pc_clr = bus.PC_Clr;
        g.ir_ld  = bus.IR_Ld;
        g.pc_up  = bus.PC_Up;
        g.d_wr   = bus.D_Wr;
        g.rf_s   = bus.RF_s;
        g.w_en   = bus.RF_W_en;
        g.d_addr = bus.D_Addr;
        g.w_addr = bus.RF_W_Addr;
        g.ra     = bus.RF_Ra_Addr;
        g.rb     = bus.RF_Rb_Addr;
        g.alu    = bus.ALU_s0;
        g.st     = bus.OutState;
        return g;
    endfunction

    // Expected per-cycle outputs from DECODE up to the cycle before the next FETCH.
    task automatic build(input logic [15:0] w, output exp_t q[$]);
        exp_t e;
        q = {};
        q.push_back(mk(ST_DECODE));
        case (w[15:12])
            4'h0: q.push_back(mk(ST_NOOP));
            4'h1: begin
                e = mk(ST_STORE);
                e.d_addr = w[11:4];
                e.ra = w[3:0];
                e.d_wr = 1'b1;
                q.push_back(e);
            end
            4'h2: begin
                e = mk(ST_LOAD_A);
                e.d_addr = w[11:4];
                e.rf_s = 1'b1;
                e.w_addr = w[3:0];
                q.push_back(e);
                e.st = 4'(ST_LOAD_B);
                e.w_en = 1'b1;
                q.push_back(e);
            end
            4'h3, 4'h4: begin
                e = mk(w[15:12] == 4'h3 ? ST_ADD : ST_SUB);
                e.ra = w[11:8];
                e.rb = w[7:4];
                e.w_addr = w[3:0];
                e.w_en = 1'b1;
                e.alu = (w[15:12] == 4'h3) ? 3'd1 : 3'd2;
                q.push_back(e);
            end
            4'h5: q.push_back(mk(ST_HALT));
`ifdef CTRL_ILLEGAL_OP_TRAP_EN
            default: q.push_back(mk(ST_HALT));
`else
            default: q.push_back(mk(ST_NOOP));
`endif
        endcase
    endtask

    task automatic check(input string tag, input exp_t e);
        exp_t g;
        g = observe();
        tests++;
        assert (g === e) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, g, e);
        end
    endtask

    // Entered #1 after the edge that put the DUT in FETCH; leaves in the next FETCH.
    task automatic run_instr(input string tag, input logic [15:0] w);
        exp_t q[$];
        build(w, q);
        check({tag, "_fetch"}, mk(ST_FETCH));
        @(posedge clk);
        #1;
        bus.IR = w;
        foreach (q[i]) begin
            check($sformatf("%s_c%0d", tag, i), q[i]);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_halt(input string tag, input logic [15:0] w);
        check({tag, "_fetch"}, mk(ST_FETCH));
        @(posedge clk);
        #1;
        bus.IR = w;
        check({tag, "_decode"}, mk(ST_DECODE));
        @(posedge clk);
        #1;
        for (int i = 0; i < 50; i++) begin
            check({tag, "_hold"}, mk(ST_HALT));
            bus.IR = 16'($urandom);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        check({tag, "_rst"}, mk(ST_INIT));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check({tag, "_init"}, mk(ST_INIT));
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        logic [3:0] op;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.IR = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_init", mk(ST_INIT));
        rst = 1'b0;
        check("release_init", mk(ST_INIT));
        @(posedge clk);
        #1;

        run_instr("load", 16'h2A53);
        run_instr("store", 16'h17F2);
        run_instr("add", 16'h3123);
        run_instr("sub", 16'h4456);
`ifndef CTRL_ILLEGAL_OP_TRAP_EN
        run_instr("illegal", 16'hF000);
`endif

        for (int n = 0; n < 40; n++) begin
`ifdef CTRL_ILLEGAL_OP_TRAP_EN
            op = 4'($urandom_range(0, 4));
`else
            op = 4'($urandom_range(0, 15));
            if (op == 4'h5) op = 4'h0;
`endif
            run_instr("rand", {op, 12'($urandom)});
        end

        // Reset in the middle of an ADD write cycle
        check("madd_fetch", mk(ST_FETCH));
        @(posedge clk);
        #1;
        bus.IR = 16'h3ABC;
        check("madd_decode", mk(ST_DECODE));
        @(posedge clk);
        #1;
        e = mk(ST_ADD);
        e.ra = 4'hA;
        e.rb = 4'hB;
        e.w_addr = 4'hC;
        e.w_en = 1'b1;
        e.alu = 3'd1;
        check("madd_exec", e);
        #2;
        rst = 1'b1;
        #1;
        check("madd_async_rst", mk(ST_INIT));
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("madd_init", mk(ST_INIT));
        @(posedge clk);
        #1;
        run_instr("post_rst", 16'h3123);

        run_halt("halt", 16'h5000);
        reset_pulse("halt_exit");
        run_instr("after_halt", 16'h4456);

`ifdef CTRL_ILLEGAL_OP_TRAP_EN
        run_halt("trap", 16'hF000);
        reset_pulse("trap_exit");
        run_instr("after_trap", 16'h0000);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
